histogram_core: RTL and testbench
=================================

HISTOGRAM_CORE -- requirements
Module: histogram_core

Interface
REQ-001 SHALL have parameter P_DW, default 8: sample width; bin count is 2^P_DW.
REQ-002 SHALL have parameter P_CW, default 16: per-bin counter width.
REQ-003 SHALL have port aclk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port areset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: pulse that clears all bins and arms accumulation.
REQ-006 SHALL have port histo_data_i, input, P_DW: sample, used as bin index.
REQ-007 SHALL have port rx_valid, input, 1: histo_data_i valid.
REQ-008 SHALL have port rx_done, input, 1: qualifies the last sample of a frame.
REQ-009 SHALL have port histo_ready, output, 1: core accepts samples.
REQ-010 SHALL have port busy, output, 1: state is CLEAR, ACCUM or FLUSH.
REQ-011 SHALL have port hist_done, output, 1: histogram complete and readable.
REQ-012 SHALL have port rd_en, input, 1: readout request.
REQ-013 SHALL have port rd_addr, input, P_DW: bin to read.
REQ-014 SHALL have port rd_data, output, P_CW: bin count.
REQ-015 SHALL have port rd_valid, output, 1: rd_data valid.
REQ-016 SHALL have port sample_cnt, output, 32: samples accepted since last start.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, ACCUM, FLUSH, DONE.
REQ-018 SHALL move IDLE->CLEAR or DONE->CLEAR on start; start in CLEAR/ACCUM/FLUSH is ignored.
REQ-019 SHALL in CLEAR write zero to bins 0..2^P_DW-1, one per cycle, zero sample_cnt, then enter ACCUM (2^P_DW cycles).
REQ-020 SHALL drive histo_ready=1 only in ACCUM; a sample is accepted when rx_valid && histo_ready.
REQ-021 SHALL ignore rx_valid and rx_done whenever histo_ready=0.
REQ-022 SHALL increment the addressed bin via 2-stage read-modify-write (read cycle N, write cycle N+1), sustaining one sample per cycle.
REQ-023 SHALL forward the pending write value when consecutive or N/N+1 samples hit the same bin; no lost increments.
REQ-024 SHALL increment sample_cnt per accepted sample, wrapping at 2^32.
REQ-025 SHALL on an accepted sample with rx_done=1 enter FLUSH, drop histo_ready next cycle, drain the pipeline (2 cycles), then enter DONE.
REQ-026 SHALL assert hist_done only in DONE.
REQ-027 SHALL honour rd_en only in DONE; rd_data/rd_valid appear 1 cycle after rd_en; rd_valid=0 otherwise.
REQ-028 SHALL hold rd_data at its last value when rd_valid=0.

Reset
REQ-029 SHALL on areset go to IDLE next edge: histo_ready=0, busy=0, hist_done=0, rd_valid=0, rd_data=0, sample_cnt=0, pipeline flushed.
REQ-030 SHALL NOT clear bin memory on reset; contents are undefined until the next CLEAR, including reset mid-ACCUM.

Configuration
REQ-031 SHALL with macro HISTO_SAT_EN defined saturate each bin at 2^P_CW-1.
REQ-032 SHALL without HISTO_SAT_EN wrap each bin modulo 2^P_CW.

Structure
REQ-033 SHALL place the state enumeration, default P_DW/P_CW and sample_cnt width in shared package histo_pkg.
REQ-034 SHALL instantiate sub-module histo_bin_ram: simple dual-port, 2^P_DW x P_CW, synchronous read latency 1, one write port.

Verification
REQ-035 SHALL cover: reset, start -> histo_ready=0 for 256 cycles, then 1; all 256 bins read 0.
REQ-036 SHALL cover: stream 0..255 back-to-back, rx_done on 255 -> every bin=1, sample_cnt=256, hist_done=1.
REQ-037 SHALL cover: 10 consecutive beats of 0x55, then 0x55/0x56 alternating 6 beats -> bin 0x55=13, bin 0x56=3.
REQ-038 SHALL cover: P_CW=4, 20 beats of 0x07 -> bin 0x07=15 with HISTO_SAT_EN, 4 without.
REQ-039 SHALL cover: areset mid-ACCUM -> next cycle histo_ready=0, busy=0, sample_cnt=0; new start re-zeroes all bins.
REQ-040 SHALL cover: rx_valid=1 during CLEAR and DONE -> no bin change, sample_cnt unchanged; rd_en outside DONE -> rd_valid=0.

Source files
------------

// File: rtl/histo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : histo_pkg                                                     |
// | Purpose  : Shared definitions for the histogram core: FSM state          |
// |            encoding, default sample/counter widths and the width of the  |
// |            accepted-sample counter.                                      |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package histo_pkg;

   localparam int C_DW_DEF   = 8;   // default sample width (2^8 bins)
   localparam int C_CW_DEF   = 16;  // default per-bin counter width
   localparam int C_SCNT_W   = 32;  // sample_cnt width

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACCUM = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } histo_state_e;

endpackage
`default_nettype wire

// File: rtl/histo_bin_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : histo_bin_ram                                                 |
// | Purpose  : Simple dual-port bin memory, 2^P_AW words of P_DW bits, one   |
// |            write port, one synchronous read port with 1-cycle latency.   |
// |            A same-address read and write in one cycle returns the old    |
// |            word; the core forwards around this case.                     |
// | Ports    : clk_i   - clock                                               |
// |            we_i    - write enable                                        |
// |            waddr_i - write address                                       |
// |            wdata_i - write data                                          |
// |            raddr_i - read address                                        |
// |            rdata_o - read data, valid one cycle after raddr_i            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module histo_bin_ram #(
   parameter int P_AW = 8,
   parameter int P_DW = 16
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [P_AW-1:0] waddr_i,
   input  logic [P_DW-1:0] wdata_i,
   input  logic [P_AW-1:0] raddr_i,
   output logic [P_DW-1:0] rdata_o
);

   // Storage is intentionally not reset; the core clears it explicitly.
   logic [P_DW-1:0] mem_q [0:(1<<P_AW)-1];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule
`default_nettype wire

// File: rtl/histogram_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : histogram_core                                                |
// | Purpose  : Streaming histogram. start clears all 2^P_DW bins (one per    |
// |            cycle), then each accepted sample increments its bin through |
// |            a 2-stage read-modify-write at one sample per cycle. A sample |
// |            with rx_done ends the frame; after a 2-cycle flush the bins  |
// |            are readable through rd_en/rd_addr.                           |
// | Config   : HISTO_SAT_EN - when defined, bins saturate at 2^P_CW-1;       |
// |            otherwise they wrap modulo 2^P_CW.                            |
// | Ports    : aclk, areset (sync, active-high)                              |
// |            start        - clear bins and arm accumulation (IDLE/DONE)    |
// |            histo_data_i - sample / bin index                             |
// |            rx_valid     - sample valid                                   |
// |            rx_done      - marks the last sample of a frame               |
// |            histo_ready  - samples accepted (ACCUM only)                  |
// |            busy         - CLEAR, ACCUM or FLUSH                          |
// |            hist_done    - histogram complete (DONE)                      |
// |            rd_en/rd_addr   - readout request (DONE only)                 |
// |            rd_data/rd_valid- readout result, one cycle after rd_en       |
// |            sample_cnt   - samples accepted since last start              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module histogram_core
   import histo_pkg::*;
#(
   parameter int P_DW = C_DW_DEF,
   parameter int P_CW = C_CW_DEF
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                start,
   input  logic [P_DW-1:0]     histo_data_i,
   input  logic                rx_valid,
   input  logic                rx_done,
   output logic                histo_ready,
   output logic                busy,
   output logic                hist_done,
   input  logic                rd_en,
   input  logic [P_DW-1:0]     rd_addr,
   output logic [P_CW-1:0]     rd_data,
   output logic                rd_valid,
   output logic [C_SCNT_W-1:0] sample_cnt
);

   localparam logic [P_DW-1:0] C_LAST_BIN = '1;

   histo_state_e          state_q, state_d;
   logic [P_DW-1:0]       clr_addr_q;
   logic                  flush_cnt_q;
   logic                  ready_q, busy_q, done_q;
   logic [C_SCNT_W-1:0]   scnt_q;

   // Pipeline: stage 1 holds the sample whose RAM read is in flight,
   // the wr_* registers remember the write issued in the previous cycle.
   logic                  s1_vld_q;
   logic [P_DW-1:0]       s1_addr_q;
   logic                  wr_vld_q;
   logic [P_DW-1:0]       wr_addr_q;
   logic [P_CW-1:0]       wr_data_q;

   logic                  rd_valid_q;
   logic [P_CW-1:0]       rd_hold_q;

   logic                  w_accept;
   logic                  w_in_clear;
   logic                  w_ram_we;
   logic [P_DW-1:0]       w_ram_waddr;
   logic [P_CW-1:0]       w_ram_wdata;
   logic [P_DW-1:0]       w_ram_raddr;
   logic [P_CW-1:0]       w_ram_rdata;
   logic [P_CW-1:0]       w_old;
   logic [P_CW-1:0]       w_new;

   assign w_accept   = rx_valid && ready_q;
   assign w_in_clear = (state_q == ST_CLEAR);

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE,
         ST_DONE:  if (start)                      state_d = ST_CLEAR;
         ST_CLEAR: if (clr_addr_q == C_LAST_BIN)   state_d = ST_ACCUM;
         ST_ACCUM: if (w_accept && rx_done)        state_d = ST_FLUSH;
         ST_FLUSH: if (flush_cnt_q)                state_d = ST_DONE;
         default:                                  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         clr_addr_q  <= '0;
         flush_cnt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= (state_d == ST_ACCUM);
         busy_q      <= (state_d == ST_CLEAR) || (state_d == ST_ACCUM) ||
                        (state_d == ST_FLUSH);
         done_q      <= (state_d == ST_DONE);
         clr_addr_q  <= w_in_clear ? clr_addr_q + P_DW'(1) : '0;
         // Two FLUSH cycles: the last write lands in the first one.
         flush_cnt_q <= (state_q == ST_FLUSH) ? ~flush_cnt_q : 1'b0;
      end
   end

   // ----------------------------------------------------- sample counter
   always_ff @(posedge aclk) begin
      if (areset || (state_d == ST_CLEAR)) begin
         scnt_q <= '0;
      end else if (w_accept) begin
         scnt_q <= scnt_q + C_SCNT_W'(1);
      end
   end

   // ------------------------------------------------ read-modify-write
   always_ff @(posedge aclk) begin
      if (areset) begin
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         s1_vld_q  <= w_accept;
         s1_addr_q <= histo_data_i;
         wr_vld_q  <= s1_vld_q;
         wr_addr_q <= s1_addr_q;
         wr_data_q <= w_new;
      end
   end

   // The RAM read for this sample was issued in the same cycle the previous
   // sample was written, so a same-bin hit must take the just-written value.
   assign w_old = (wr_vld_q && (wr_addr_q == s1_addr_q)) ? wr_data_q : w_ram_rdata;

`ifdef HISTO_SAT_EN
   assign w_new = (w_old == '1) ? w_old : w_old + P_CW'(1);
`else
   assign w_new = w_old + P_CW'(1);
`endif

   // CLEAR and pending increments never overlap, so one write port serves both.
   assign w_ram_we    = w_in_clear || s1_vld_q;
   assign w_ram_waddr = w_in_clear ? clr_addr_q : s1_addr_q;
   assign w_ram_wdata = w_in_clear ? '0 : w_new;
   assign w_ram_raddr = (state_q == ST_DONE) ? rd_addr : histo_data_i;

   histo_bin_ram #(
      .P_AW (P_DW),
      .P_DW (P_CW)
   ) u_bin_ram (
      .clk_i   (aclk),
      .we_i    (w_ram_we),
      .waddr_i (w_ram_waddr),
      .wdata_i (w_ram_wdata),
      .raddr_i (w_ram_raddr),
      .rdata_o (w_ram_rdata)
   );

   // ------------------------------------------------------------ readout
   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_valid_q <= 1'b0;
         rd_hold_q  <= '0;
      end else begin
         rd_valid_q <= rd_en && (state_q == ST_DONE);
         if (rd_valid_q) begin
            rd_hold_q <= w_ram_rdata;
         end
      end
   end

   assign rd_data     = rd_valid_q ? w_ram_rdata : rd_hold_q;
   assign rd_valid    = rd_valid_q;
   assign histo_ready = ready_q;
   assign busy        = busy_q;
   assign hist_done   = done_q;
   assign sample_cnt  = scnt_q;

endmodule
`default_nettype wire

// File: tb/tb_histogram_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_histogram_core                                             |
// | Purpose  : Self-checking bench for histogram_core (P_DW=8, P_CW=4).      |
// |            Directed frames plus a randomized frame compared against a    |
// |            per-bin count array. Honours HISTO_SAT_EN like the design.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_histogram_core;

   localparam int DW = 8;
   localparam int CW = 4;
   localparam int NB = 1 << DW;

   logic          aclk = 1'b0;
   logic          areset;
   logic          start;
   logic [DW-1:0] histo_data_i;
   logic          rx_valid;
   logic          rx_done;
   logic          histo_ready;
   logic          busy;
   logic          hist_done;
   logic          rd_en;
   logic [DW-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic          rd_valid;
   logic [31:0]   sample_cnt;

   int            errors = 0;
   int            checks = 0;
   int unsigned   model [NB];
   int unsigned   exp_cnt;

   always #5 aclk = ~aclk;

   histogram_core #(
      .P_DW (DW),
      .P_CW (CW)
   ) dut (
      .aclk         (aclk),
      .areset       (areset),
      .start        (start),
      .histo_data_i (histo_data_i),
      .rx_valid     (rx_valid),
      .rx_done      (rx_done),
      .histo_ready  (histo_ready),
      .busy         (busy),
      .hist_done    (hist_done),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .sample_cnt   (sample_cnt)
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned bump(input int unsigned v);
`ifdef HISTO_SAT_EN
      return (v >= (1 << CW) - 1) ? v : v + 1;
`else
      return (v + 1) % (1 << CW);
`endif
   endfunction

   // Start a frame with junk samples offered during the clear phase.
   task automatic start_frame();
      int n;
      for (int i = 0; i < NB; i++) model[i] = 0;
      exp_cnt  = 0;
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_done  = 1'b1;
      histo_data_i = DW'($urandom);
      tick();
      start = 1'b0;
      chk("busy_clear", busy, 1);
      n = 0;
      while (histo_ready !== 1'b1 && n < 400) begin
         n++;
         histo_data_i = DW'($urandom);
         rx_done      = 1'($urandom);
         tick();
      end
      rx_valid = 1'b0;
      rx_done  = 1'b0;
      chk("clear_len", n, 256);
      chk("cnt_after_clear", sample_cnt, 0);
   endtask

   task automatic send(input logic [DW-1:0] d, input logic dn);
      rx_valid     = 1'b1;
      histo_data_i = d;
      rx_done      = dn;
      if (histo_ready === 1'b1) begin
         model[d] = bump(model[d]);
         exp_cnt++;
      end
      tick();
   endtask

   task automatic finish_frame();
      int n;
      rx_valid = 1'b0;
      rx_done  = 1'b0;
      chk("ready_drop", histo_ready, 0);
      chk("busy_flush", busy, 1);
      n = 0;
      while (hist_done !== 1'b1 && n < 10) begin
         n++;
         tick();
      end
      chk("flush_len", n, 2);
      chk("busy_done", busy, 0);
      chk("sample_cnt", sample_cnt, exp_cnt);
   endtask

   task automatic read_bin(input logic [DW-1:0] a, output logic [CW-1:0] d);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en = 1'b0;
      chk("rd_valid_single", rd_valid, 1);
      d = rd_data;
   endtask

   task automatic read_all();
      for (int a = 0; a < NB; a++) begin
         rd_en   = 1'b1;
         rd_addr = DW'(a);
         tick();
         chk("rd_valid", rd_valid, 1);
         chk("bin", rd_data, model[a]);
      end
      rd_en = 1'b0;
      tick();
      chk("rd_valid_idle", rd_valid, 0);
      chk("rd_data_hold", rd_data, model[NB-1]);
   endtask

   initial begin
      logic [CW-1:0] d;
      logic [DW-1:0] v;
      areset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_done = 1'b0;
      rd_en = 1'b0; rd_addr = '0; histo_data_i = '0;
      repeat (3) tick();
      chk("rst_ready", histo_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", hist_done, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_cnt", sample_cnt, 0);
      areset = 1'b0;
      tick();

      // Readout request in IDLE is ignored.
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      chk("rd_idle", rd_valid, 0);

      // Frame 1: one sample; samples offered in DONE are ignored.
      start_frame();
      send(DW'($urandom), 1'b1);
      finish_frame();
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'b1; histo_data_i = DW'($urandom); rx_done = 1'($urandom);
         tick();
      end
      rx_valid = 1'b0; rx_done = 1'b0;
      chk("cnt_in_done", sample_cnt, exp_cnt);
      chk("done_hold", hist_done, 1);
      read_all();

      // Frame 2: every bin once, back to back.
      start_frame();
      for (int i = 0; i < NB; i++) send(DW'(i), i == NB - 1);
      finish_frame();
      chk("cnt_256", sample_cnt, 256);
      chk("hist_done", hist_done, 1);
      read_all();

      // Frame 3: same-bin and alternating-bin hazards.
      start_frame();
      for (int i = 0; i < 10; i++) send(8'h55, 1'b0);
      for (int k = 0; k < 6; k++) send((k % 2) ? 8'h56 : 8'h55, k == 5);
      finish_frame();
      read_bin(8'h55, d); chk("bin55", d, 13);
      read_bin(8'h56, d); chk("bin56", d, 3);
      read_all();

      // Frame 4: counter overflow on a single bin.
      start_frame();
      for (int i = 0; i < 20; i++) send(8'h07, i == 19);
      finish_frame();
      read_bin(8'h07, d);
`ifdef HISTO_SAT_EN
      chk("bin07_sat", d, 15);
`else
      chk("bin07_wrap", d, 4);
`endif
      read_all();

      // Frame 5: random samples with gaps, stray rx_done and rd_en in ACCUM.
      start_frame();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            rx_done  = 1'($urandom);
            rd_en    = 1'b1;
            rd_addr  = DW'($urandom);
            tick();
            rd_en = 1'b0;
            if (i % 16 == 0) chk("rd_in_accum", rd_valid, 0);
         end else begin
            v = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            send(v, 1'b0);
         end
      end
      send(DW'($urandom_range(0, 3)), 1'b1);
      finish_frame();
      read_all();

      // Frame 6: reset during accumulation, then a fresh frame.
      start_frame();
      for (int i = 0; i < 20; i++) send(DW'($urandom_range(0, 7)), 1'b0);
      areset = 1'b1; rx_valid = 1'b0;
      tick();
      chk("mid_rst_ready", histo_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", sample_cnt, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      areset = 1'b0;
      tick();
      start_frame();
      send(DW'($urandom_range(0, 7)), 1'b1);
      finish_frame();
      read_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
